// File: rtl/dsp_sched_pkg.sv
// Shared types for the DSP scheduler: FSM states, operand-mode codes, issue lengths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t, MODE_* encodings, ISSUE_* cycle counts, issue_cycles() helper.
package dsp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_8X8     = 2'd0;
  localparam logic [1:0] MODE_16X8    = 2'd1;
  localparam logic [1:0] MODE_16X16   = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int ISSUE_8X8   = 1;
  localparam int ISSUE_16X8  = 2;
  localparam int ISSUE_16X16 = 4;

  // Number of cycles the DSP needs its operands presented for a given mode.
  function automatic logic [2:0] issue_cycles(input logic [1:0] mode);
    case (mode)
      MODE_8X8:   issue_cycles = 3'(ISSUE_8X8);
      MODE_16X8:  issue_cycles = 3'(ISSUE_16X8);
      MODE_16X16: issue_cycles = 3'(ISSUE_16X16);
      default:    issue_cycles = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dsp_sched_if.sv
// Request/response bundle between two requesters and the DSP scheduler.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester; the response strobe cannot be stalled.
// Ports: req_valid/req_ready[2], per-requester operands a/b/c, mode, mac, shift;
//        resp_valid/resp_id/resp_err/resp_data. master = requester side, slave = scheduler.
interface dsp_sched_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][N-1:0]       req_a;
  logic [1:0][M-1:0]       req_b;
  logic [1:0][N+M-1:0]     req_c;
  logic [1:0][1:0]         req_mode;
  logic [1:0]              req_mac;
  logic [1:0][1:0]         req_shift;
  logic                    resp_valid;
  logic                    resp_id;
  logic                    resp_err;
  logic [N+M-1:0]          resp_data;

  modport master (
    output req_valid, req_a, req_b, req_c, req_mode, req_mac, req_shift,
    input  req_ready, resp_valid, resp_id, resp_err, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_mode, req_mac, req_shift,
    output req_ready, resp_valid, resp_id, resp_err, resp_data
  );
endinterface

// File: rtl/dsp_sched_rr_arb2.sv
// Two-requester round-robin grant; the requester not served last wins a tie.
// Latency: grant is combinational from req/en; pointer updates on the grant edge.
// Backpressure: grants only while en is high; a dropped request simply gets no grant.
// Ports: clk, rst_n, en, req[1:0] in; gnt[1:0] out (one-hot or zero).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;  // requester that wins when both are valid

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // gnt is only ever raised on a valid requester and is used directly as
  // ready, so any grant is a handshake and moves the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end
endmodule

// File: rtl/dsp_sched.sv
// Arbitrates two requesters onto one multi-cycle DSP and returns its result.
// Latency: handshake -> resp_valid in issue(1/2/4)+RES_LAT+1 cycles; illegal mode in 1.
// Backpressure: one op in flight; req_ready only in IDLE; response is never stalled.
// Ports: clk, rst_n, bus (dsp_sched_if.slave), dsp_start/mac/mode/shift/aa/bb/cc out,
//        dsp_out in, perf_ops/perf_busy out. Counters exist only with DSP_SCHED_PERF_EN.
module dsp_sched
  import dsp_sched_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int RES_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dsp_sched_if.slave       bus,
  output logic             dsp_start,
  output logic             dsp_mac,
  output logic [1:0]       dsp_mode,
  output logic [1:0]       dsp_shift,
  output logic [N-1:0]     dsp_aa,
  output logic [M-1:0]     dsp_bb,
  output logic [N+M-1:0]   dsp_cc,
  input  logic [N+M-1:0]   dsp_out,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_busy
);
  state_t     state;
  logic [7:0] cnt;     // remaining ISSUE or DRAIN cycles minus one
  logic       cur_id;
  logic       live;    // holds off grants until the first edge after reset release
  logic [1:0] gnt;
  logic       sel;
  logic       hs;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (live && (state == ST_IDLE)),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt;
  assign sel           = gnt[1];
  assign hs            = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      cur_id         <= 1'b0;
      live           <= 1'b0;
      dsp_start      <= 1'b0;
      dsp_mac        <= 1'b0;
      dsp_mode       <= '0;
      dsp_shift      <= '0;
      dsp_aa         <= '0;
      dsp_bb         <= '0;
      dsp_cc         <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      live           <= 1'b1;
      dsp_start      <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            cur_id <= sel;
            if (bus.req_mode[sel] == MODE_ILLEGAL) begin
              // Illegal ops bypass the DSP entirely: its outputs keep the previous op.
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_id    <= sel;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= '0;
            end else begin
              state     <= ST_ISSUE;
              cnt       <= 8'(issue_cycles(bus.req_mode[sel])) - 8'd1;
              dsp_start <= 1'b1;
              dsp_mac   <= bus.req_mac[sel];
              dsp_mode  <= bus.req_mode[sel];
              dsp_shift <= bus.req_shift[sel];
              dsp_aa    <= bus.req_a[sel];
              dsp_bb    <= bus.req_b[sel];
              dsp_cc    <= bus.req_c[sel];
            end
          end
        end
        ST_ISSUE: begin
          if (cnt == 8'd0) begin
            state   <= ST_DRAIN;
            cnt     <= 8'(RES_LAT - 1);
            dsp_mac <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_DRAIN: begin
          // Final DRAIN cycle is RES_LAT cycles after the last ISSUE cycle,
          // which is when the DSP result becomes valid.
          if (cnt == 8'd0) begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= cur_id;
            bus.resp_err   <= 1'b0;
            bus.resp_data  <= dsp_out;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef DSP_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (state == ST_RESP) perf_ops  <= perf_ops + 32'd1;
      if (state != ST_IDLE) perf_busy <= perf_busy + 32'd1;
    end
  end
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_dsp_sched.sv
// Directed bench for dsp_sched with a two-stage pipelined multiply-add DSP model.
// Latency: model result = aa*bb+cc of the operands two cycles earlier.
// Backpressure: requests are driven one at a time except for the arbitration step.
module tb_dsp_sched;
  localparam int N = 16;
  localparam int M = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dsp_start, dsp_mac;
  logic [1:0] dsp_mode, dsp_shift;
  logic [N-1:0] dsp_aa;
  logic [M-1:0] dsp_bb;
  logic [N+M-1:0] dsp_cc, dsp_out, p1;
  logic [31:0] perf_ops, perf_busy;

  int vectors = 0;
  int miscompares = 0;

  dsp_sched_if #(.N(N), .M(M)) bus ();

  dsp_sched #(.N(N), .M(M), .RES_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dsp_start (dsp_start),
    .dsp_mac   (dsp_mac),
    .dsp_mode  (dsp_mode),
    .dsp_shift (dsp_shift),
    .dsp_aa    (dsp_aa),
    .dsp_bb    (dsp_bb),
    .dsp_cc    (dsp_cc),
    .dsp_out   (dsp_out),
    .perf_ops  (perf_ops),
    .perf_busy (perf_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1      <= dsp_aa * dsp_bb + dsp_cc;
    dsp_out <= p1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle at posedge+1; ends in the IDLE cycle after RESP.
  task automatic do_op(input int id, input logic [1:0] mode, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] c, input logic mac,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat, input int exp_issue);
    int cyc = 1;
    int nstart = 0;
    int nmac = 0;
    int nready = 0;
    int nbad = 0;
    bit got = 0;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_c[id]     = c;
    bus.req_mode[id]  = mode;
    bus.req_mac[id]   = mac;
    bus.req_shift[id] = 2'd1;
    bus.req_valid[id] = 1'b1;
    #1;
    chk("op_ready", bus.req_ready, (id == 0) ? 2'b01 : 2'b10);
    step();
    bus.req_valid[id] = 1'b0;
    if (!exp_err) chk("op_mode", dsp_mode, mode);
    while (!got && cyc <= 20) begin
      nstart += int'(dsp_start);
      nmac   += int'(dsp_mac);
      if (bus.req_ready != 2'b00) nready++;
      if (!exp_err && cyc < exp_lat - 1 &&
          (dsp_aa !== a || dsp_bb !== b || dsp_cc !== c)) nbad++;
      if (bus.resp_valid) begin
        got = 1;
        chk("op_latency", cyc, exp_lat);
        chk("op_id", bus.resp_id, id[0]);
        chk("op_err", bus.resp_err, exp_err);
        chk("op_data", bus.resp_data, exp_data);
      end else begin
        step();
        cyc++;
      end
    end
    chk("op_resp_seen", got, 1'b1);
    chk("op_starts", nstart, exp_err ? 0 : 1);
    chk("op_mac_cycles", nmac, mac ? exp_issue : 0);
    chk("op_ready_busy", nready, 0);
    chk("op_operand_hold", nbad, 0);
    step();
    chk("op_resp_one_cycle", bus.resp_valid, 1'b0);
  endtask

  int gseq[4];
  int gcyc[4];
  int ng;
  int nresp;

  initial begin
    bus.req_valid = 2'b01;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.req_mode = '0; bus.req_mac = '0; bus.req_shift = '0;

    // Reset state
    step(); step();
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_start", dsp_start, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_dsp_aa", dsp_aa, 16'h0);
    chk("rst_dsp_cc", dsp_cc, 32'h0);
    chk("rst_perf_ops", perf_ops, 32'h0);
    chk("rst_perf_busy", perf_busy, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_no_early_grant", bus.req_ready, 2'b00);
    step();
    chk("rel_first_grant", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    step();
    chk("drop_no_resp", bus.resp_valid, 1'b0);

    // 8x8 from requester 0: 3*5 = 15, resp 4 cycles after handshake
    do_op(0, 2'd0, 16'd3, 16'd5, 32'd0, 1'b0, 32'd15, 1'b0, 4, 1);
    // 16x16 from requester 1: 0x1234*0x10 = 0x12340, 4 issue cycles
    do_op(1, 2'd2, 16'h1234, 16'h0010, 32'd0, 1'b1, 32'h00012340, 1'b0, 7, 4);

    // Both requesters valid continuously: expect 0,1,0,1 every 5 cycles
    bus.req_mode = '0; bus.req_mac = '0;
    bus.req_a[0] = 16'h0011; bus.req_a[1] = 16'h0022;
    bus.req_b[0] = 16'h0001; bus.req_b[1] = 16'h0001;
    bus.req_c = '0;
    bus.req_valid = 2'b11;
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        gseq[ng] = int'(bus.req_ready[1]);
        gcyc[ng] = k;
        ng++;
      end
      step();
    end
    bus.req_valid = 2'b00;
    chk("alt_grants", ng, 4);
    chk("alt_g0", gseq[0], 0);
    chk("alt_g1", gseq[1], 1);
    chk("alt_g2", gseq[2], 0);
    chk("alt_g3", gseq[3], 1);
    chk("alt_spacing", gcyc[1] - gcyc[0], 5);
    repeat (4) step();

    // Illegal mode: error response, no DSP activity
    do_op(0, 2'd3, 16'hAAAA, 16'h5555, 32'h1, 1'b1, 32'h0, 1'b1, 1, 0);
    chk("illegal_no_dsp", dsp_aa, 16'h0022);

    // Reset in the middle of a 16x16 issue
    bus.req_a[0] = 16'h0F0F; bus.req_b[0] = 16'h0002; bus.req_c[0] = '0;
    bus.req_mode[0] = 2'd2; bus.req_mac[0] = 1'b1;
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("mid_start", dsp_start, 1'b1);
    step();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("mid_rst_start", dsp_start, 1'b0);
    chk("mid_rst_mac", dsp_mac, 1'b0);
    chk("mid_rst_aa", dsp_aa, 16'h0);
    chk("mid_rst_ready", bus.req_ready, 2'b00);
    nresp = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      nresp += int'(bus.resp_valid);
    end
    rst_n = 1'b1;
    step();
    chk("mid_ptr_reset", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      step();
      nresp += int'(bus.resp_valid);
    end
    chk("mid_no_resp", nresp, 0);

    // Three 16x8 ops after reset
    do_op(0, 2'd1, 16'h0102, 16'h0003, 32'h10, 1'b0, 32'h00000316, 1'b0, 5, 2);
    do_op(1, 2'd1, 16'h00FF, 16'h00FF, 32'h0,  1'b0, 32'h0000FE01, 1'b0, 5, 2);
    do_op(0, 2'd1, 16'h8000, 16'h0002, 32'h1,  1'b0, 32'h00010001, 1'b0, 5, 2);
`ifdef DSP_SCHED_PERF_EN
    chk("perf_ops", perf_ops, 32'd3);
    chk("perf_busy", perf_busy, 32'd15);
`else
    chk("perf_ops", perf_ops, 32'd0);
    chk("perf_busy", perf_busy, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dsp_sched.md
DSP_SCHED -- requirements
Module: dsp_sched

Interface
REQ-001 Parameter N, default 16: operand A width.
REQ-002 Parameter M, default 16: operand B width.
REQ-003 Parameter RES_LAT, default 2: cycles from the last issue cycle to a valid DSP result.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request valid.
REQ-007 req_ready  out  2  per-requester accept; a handshake occurs when valid&ready.
REQ-008 req_a / req_b / req_c  in  2x N / 2x M / 2x (N+M)  per-requester operands and addend.
REQ-009 req_mode  in  2x2  0: 8x8, 1: 16x8, 2: 16x16, 3: illegal.
REQ-010 req_mac / req_shift  in  2x1 / 2x2  accumulate enable / accumulator barrel shift.
REQ-011 dsp_start, dsp_mac  out  1  start and accumulate controls to the DSP.
REQ-012 dsp_mode, dsp_shift  out  2  mode and barrel-shift controls to the DSP.
REQ-013 dsp_aa, dsp_bb, dsp_cc  out  N, M, N+M  DSP operands.
REQ-014 dsp_out  in  N+M  DSP result.
REQ-015 resp_valid, resp_id, resp_err  out  1, 1, 1  one-cycle response strobe, owning requester, illegal-mode flag.
REQ-016 resp_data  out  N+M  captured result.
REQ-017 perf_ops, perf_busy  out  32, 32  performance counters (REQ-033).

Function
REQ-018 State machine SHALL have states IDLE, ISSUE, DRAIN, RESP.
REQ-019 In IDLE, req_ready SHALL be asserted only to the round-robin winner among valid requesters; the winner is granted only when its valid is high; req_ready is 0 in all other states.
REQ-020 Round-robin: the requester not granted most recently wins a tie; after reset requester 0 has priority.
REQ-021 On a handshake, operands, mode, mac, shift and id SHALL be latched; the state moves to ISSUE, or to RESP with resp_err=1 and resp_data=0 if mode==3. An illegal op SHALL drive no DSP activity.
REQ-022 ISSUE SHALL last 1, 2 or 4 cycles for mode 0, 1 or 2; dsp_start=1 in the first ISSUE cycle only.
REQ-023 dsp_aa/bb/cc/mode/mac/shift SHALL hold the latched values for every ISSUE cycle and RES_LAT-1 following cycles.
REQ-024 Outside ISSUE, dsp_start=0 and dsp_mac=0; the other DSP outputs hold their last values.
REQ-025 DRAIN SHALL last RES_LAT cycles counted from the last ISSUE cycle; dsp_out SHALL be captured into resp_data on the final DRAIN cycle.
REQ-026 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; no backpressure on the response.
REQ-027 Minimum request-to-request spacing SHALL be ISSUE+RES_LAT+2 cycles; back-to-back ops from the same requester are legal.
REQ-028 A requester dropping req_valid before the handshake SHALL be legal and SHALL cause no grant.

Reset
REQ-029 On rst_n low, in the same or next clock: state IDLE, all outputs 0, round-robin pointer set to requester 0, counters 0.
REQ-030 Reset mid-operation SHALL abandon the op with no response; dsp_start SHALL be 0 throughout reset.
REQ-031 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro DSP_SCHED_PERF_EN SHALL gate the performance counters.
REQ-033 With the macro defined: perf_ops increments once per RESP cycle; perf_busy increments every cycle not in IDLE; both wrap at 2^32. Without the macro: both ports are tied to 0 and no counter flops exist.

Structure
REQ-034 Package dsp_sched_pkg SHALL hold the state enum, the mode encodings and the per-mode issue-cycle constants (1/2/4).
REQ-035 One sub-module rr_arb2 SHALL implement the 2-requester round-robin grant and pointer.

Verification
REQ-036 Req0 mode 0, a=3, b=5, c=0, RES_LAT=2 -> one dsp_start; resp_valid 4 cycles after the handshake cycle; resp_id=0; resp_data equals dsp_out at capture (15 with the DSP model).
REQ-037 Req1 mode 2, a=0x1234, b=0x0010 -> ISSUE 4 cycles with stable operands; resp_data=0x00012340; resp_id=1.
REQ-038 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; no grant occurs outside IDLE.
REQ-039 Mode 3 from req0 -> resp_err=1, resp_data=0, dsp_start never asserted.
REQ-040 rst_n asserted in ISSUE of a mode 2 op -> no resp_valid; outputs 0; the next op completes normally.
REQ-041 With DSP_SCHED_PERF_EN, three mode 1 ops -> perf_ops=3, perf_busy=3x(2+2+1)=15; without the macro both read 0.
